// File: rtl/kanade_mem_responder.sv
// Responder for the KANADE32 core memory port: on-chip RAM plus MMIO (cycle counter, scratch, timer).
// Define KANADE_RESP_TIMER_EN to build the compare timer (TCNT/TCMP/TCTRL/TSTAT) and its irq.
module kanade_mem_responder #(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter logic [29:0] MMIO_BASE  = 30'h3FFFFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] address,
  input  logic [31:0] data,
  input  logic [3:0]  byteena_a,
  input  logic        wren,
  output logic [31:0] q,
  output logic        irq
);

  localparam int unsigned RamDepth = 2 ** RAM_ADDR_W;

  localparam logic [3:0] OffCycLo   = 4'd0;
  localparam logic [3:0] OffCycHi   = 4'd1;
  localparam logic [3:0] OffTcnt    = 4'd2;
  localparam logic [3:0] OffTcmp    = 4'd3;
  localparam logic [3:0] OffTctrl   = 4'd4;
  localparam logic [3:0] OffTstat   = 4'd5;
  localparam logic [3:0] OffScratch = 4'd6;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic [3:0]            mmio_off;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  ram_we;
  logic                  mmio_we;
  logic [31:0]           lane_mask;

  assign ram_idx  = address[RAM_ADDR_W-1:0];
  assign mmio_off = address[3:0];
  assign ram_hit  = (address[29:RAM_ADDR_W] == '0);
  assign mmio_hit = (address[29:4] == MMIO_BASE[29:4]);

  // A write presented on a reset edge is dropped, RAM included.
  assign ram_we  = wren & ram_hit & ~reset;
  assign mmio_we = wren & mmio_hit & ~reset;

  assign lane_mask = {{8{byteena_a[3]}}, {8{byteena_a[2]}},
                      {8{byteena_a[1]}}, {8{byteena_a[0]}}};

  // ---------------------------------------------------------------------------
  // On-chip RAM: contents survive reset, per-lane write enables
  // ---------------------------------------------------------------------------
  logic [31:0] mem [RamDepth];

  always_ff @(posedge clk) begin
    if (ram_we && byteena_a[3]) mem[ram_idx][31:24] <= data[31:24];
    if (ram_we && byteena_a[2]) mem[ram_idx][23:16] <= data[23:16];
    if (ram_we && byteena_a[1]) mem[ram_idx][15:8]  <= data[15:8];
    if (ram_we && byteena_a[0]) mem[ram_idx][7:0]   <= data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Cycle counter, coherent high-word shadow, scratch register
  // ---------------------------------------------------------------------------
  logic [63:0] cycle_q;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;

  always_comb begin
    shadow_d = shadow_q;
    // Any access to CYC_LO is a read, so the shadow follows it even when wren is set.
    if (mmio_hit && (mmio_off == OffCycLo)) begin
      shadow_d = cycle_q[63:32];
    end
    scratch_d = scratch_q;
    if (mmio_we && (mmio_off == OffScratch)) begin
      scratch_d = lane_merge(scratch_q, data, lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      shadow_q  <= '0;
      scratch_q <= '0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare timer
  // ---------------------------------------------------------------------------
  logic [31:0] timer_rdata;

`ifdef KANADE_RESP_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [2:0]  tctrl_q, tctrl_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  logic        match;
  logic [31:0] tcnt_auto;

  always_comb begin
    match     = tctrl_q[0] && (tcnt_q == tcmp_q);
    tcnt_auto = tcnt_q;
    if (tctrl_q[0]) begin
      tcnt_auto = (match && tctrl_q[1]) ? 32'd0 : tcnt_q + 32'd1;
    end

    // Software write wins over the automatic update on written lanes.
    tcnt_d = tcnt_auto;
    if (mmio_we && (mmio_off == OffTcnt)) begin
      tcnt_d = lane_merge(tcnt_auto, data, lane_mask);
    end

    tcmp_d = tcmp_q;
    if (mmio_we && (mmio_off == OffTcmp)) begin
      tcmp_d = lane_merge(tcmp_q, data, lane_mask);
    end

    tctrl_d = tctrl_q;
    if (mmio_we && (mmio_off == OffTctrl) && byteena_a[0]) begin
      tctrl_d = data[2:0];
    end

    // Set beats W1C clear in the same cycle.
    flag_d = flag_q;
    if (mmio_we && (mmio_off == OffTstat) && byteena_a[0] && data[0]) begin
      flag_d = 1'b0;
    end
    if (match) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      tctrl_q <= '0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
      flag_q  <= flag_d;
      irq_q   <= flag_q & tctrl_q[2];
    end
  end

  always_comb begin
    timer_rdata = '0;
    case (mmio_off)
      OffTcnt:  timer_rdata = tcnt_q;
      OffTcmp:  timer_rdata = tcmp_q;
      OffTctrl: timer_rdata = {29'd0, tctrl_q};
      OffTstat: timer_rdata = {31'd0, flag_q};
      default:  timer_rdata = '0;
    endcase
  end

  assign irq = irq_q;
`else
  assign timer_rdata = '0;
  assign irq         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: one registered stage for every access
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata;
  logic [31:0] rdata;
  logic [31:0] q_q;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OffCycLo:   mmio_rdata = cycle_q[31:0];
      OffCycHi:   mmio_rdata = shadow_q;
      OffTcnt,
      OffTcmp,
      OffTctrl,
      OffTstat:   mmio_rdata = timer_rdata;
      OffScratch: mmio_rdata = scratch_q;
      default:    mmio_rdata = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = mem[ram_idx];
    end else if (mmio_hit) begin
      rdata = mmio_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= rdata;
    end
  end

  assign q = q_q;

endmodule
